sequential_divider: RTL and testbench

Unsigned N-bit sequential restoring divider: the inverse companion to the team's N-bit `SequentialMultiplier`. It accepts a dividend and divisor under the same start/ready handshake. It produces an N-bit quotient and an N-bit remainder after exactly N iteration cycles. Together the two blocks give the datapath multicycle multiply and divide, both driven by one controller protocol.

---
 rtl/sequential_divider.sv | 113 +++++++++++
 tb/tb_sequential_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Unsigned N-bit sequential restoring divider: one quotient bit per clock, N cycles per
// operation, using the same start/ready handshake as the companion sequential multiplier.
module sequential_divider #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         start,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         ready
);

    localparam int              CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    // The partial remainder is always below the divisor between iterations, so its
    // (N+1)-th bit is always zero and only N bits are stored; the trial keeps N+1 bits.
    logic [N-1:0]     p;
    logic [N-1:0]     d;
    logic [N-1:0]     v;
    logic [CNT_W-1:0] cnt;
    logic             zero_flag;

    logic             accept;
    logic             last_iter;
    logic [N:0]       p_shift;
    logic [N:0]       trial;
    logic [N-1:0]     p_iter;
    logic [N-1:0]     d_iter;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, like real flops.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        accept    = (state == IDLE) && start;
        last_iter = (state == BUSY) && (cnt == LAST);
    end

    // One restoring step: shift {P,D}, trial-subtract V, keep the difference if non-negative.
    always_comb begin
        p_shift = {p, d[N-1]};
        trial   = p_shift - {1'b0, v};
        p_iter  = p_shift[N-1:0];
        d_iter  = {d[N-2:0], 1'b0};
        if (!trial[N]) begin
            p_iter    = trial[N-1:0];
            d_iter[0] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p         <= '0;
            d         <= '0;
            v         <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
        end else if (accept) begin
            p         <= '0;
            d         <= dividend;
            v         <= divisor;
            cnt       <= '0;
            zero_flag <= (divisor == '0);
        end else if (state == BUSY) begin
            p   <= p_iter;
            d   <= d_iter;
            cnt <= last_iter ? '0 : cnt + CNT_W'(1);
        end
    end

    // Results change only on the completion edge and hold through the next operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (last_iter) begin
            quotient    <= d_iter;
            remainder   <= p_iter;
            div_by_zero <= zero_flag;
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and randomised checks of sequential_divider (N=8): reset values, latency,
// result hold during BUSY, divide by zero, back-to-back operation and mid-operation reset.
module tb_sequential_divider;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         ready;

    int total  = 0;
    int passed = 0;

    logic [N-1:0] prev_q = '0;
    logic [N-1:0] prev_r = '0;
    logic         prev_z = 1'b0;

    sequential_divider #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .dividend   (dividend),
        .divisor    (divisor),
        .start      (start),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .ready      (ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Called just after a falling edge with ready=1. Returns at the falling edge where
    // ready is seen high again; start stays high unless dropped at busy negedge drop_at.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] q_exp, input logic [N-1:0] r_exp,
                          input logic z_exp, input int drop_at, input string tag);
        int busy;
        bit hold_ok;
        bit done;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        busy    = 0;
        hold_ok = 1'b1;
        done    = 1'b0;
        while (!done && busy <= N + 2) begin
            @(negedge clock);
            if (ready) begin
                done = 1'b1;
            end else begin
                if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_z)
                    hold_ok = 1'b0;
                if (busy == drop_at) start = 1'b0;
                dividend = N'($urandom);
                divisor  = N'($urandom);
                busy++;
            end
        end
        check({tag, "_timeout"}, 32'(done), 32'(1));
        check({tag, "_latency"}, 32'(busy), 32'(N));
        check({tag, "_hold"}, 32'(hold_ok), 32'(1));
        check({tag, "_q"}, 32'(quotient), 32'(q_exp));
        check({tag, "_r"}, 32'(remainder), 32'(r_exp));
        check({tag, "_z"}, 32'(div_by_zero), 32'(z_exp));
        prev_q = q_exp;
        prev_r = r_exp;
        prev_z = z_exp;
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q_exp;
        logic [N-1:0] r_exp;
        logic         z_exp;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_q", 32'(quotient), 32'(0));
        check("rst_r", 32'(remainder), 32'(0));
        check("rst_z", 32'(div_by_zero), 32'(0));
        reset = 1'b0;
        @(negedge clock);

        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0, "d100_7");
        run_op(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 0, "d5_0");
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 0, "d9_3");
        run_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 0, "d3_200");
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0, "d255_1");
        run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 0, "d255_255");
        run_op(8'd0, 8'd0, 8'd255, 8'd0, 1'b1, 0, "d0_0");

        // start held high: operands scrambled every busy cycle, one ready cycle between ops
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, N, "chain1");
        run_op(8'd77, 8'd10, 8'd7, 8'd7, 1'b0, N, "chain2");
        run_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 3, "chain3");
        @(negedge clock);
        check("chain_idle_ready", 32'(ready), 32'(1));

        // reset asserted after iteration 4 of 200/9
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("mid_busy", 32'(ready), 32'(0));
        check("mid_hold_q", 32'(quotient), 32'(prev_q));
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ready), 32'(1));
        check("mid_rst_q", 32'(quotient), 32'(0));
        check("mid_rst_r", 32'(remainder), 32'(0));
        check("mid_rst_z", 32'(div_by_zero), 32'(0));
        @(negedge clock);
        reset  = 1'b0;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        run_op(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 0, "rst_redo");

        for (int i = 0; i < 256; i++) begin
            a = N'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
            if (b == '0) begin
                q_exp = '1;
                r_exp = a;
                z_exp = 1'b1;
            end else begin
                q_exp = a / b;
                r_exp = a % b;
                z_exp = 1'b0;
            end
            repeat ($urandom_range(0, 4)) @(negedge clock);
            run_op(a, b, q_exp, r_exp, z_exp, int'($urandom_range(0, N - 1)), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
